// File: rtl/adc_sample_scheduler_pkg.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_scheduler_pkg
// Description : Shared types and helpers for the ADC sample scheduler.
//               - sched_state_t : acquisition FSM state encoding
//               - C_CNT_W       : width of the statistics counters
//               - sat_inc()     : saturating increment for those counters
// Revision    : 1.0 - initial release
// ============================================================================
package adc_sample_scheduler_pkg;

  localparam int C_CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WAIT_TICK = 3'd1,
    S_ARM       = 3'd2,
    S_CONVERT   = 3'd3,
    S_NEXT      = 3'd4,
    S_FINISH    = 3'd5
  } sched_state_t;

  // Counters stick at all-ones rather than wrapping back to zero.
  function automatic logic [C_CNT_W-1:0] sat_inc(input logic [C_CNT_W-1:0] v);
    return (v == {C_CNT_W{1'b1}}) ? v : v + 1'b1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_sample_scheduler_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_scheduler_tick_gen
// Description : Sweep pacing counter. Counts 0..TICK_DIV-1 while enabled and
//               pulses o_tick for one cycle on the terminal count.
// Ports       : i_clk   - system clock
//               i_rst   - synchronous active-high reset
//               i_clr   - restart the count from zero (acquisition start)
//               i_en    - count enable (acquisition busy)
//               o_tick  - one-cycle tick at count TICK_DIV-1
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_scheduler_tick_gen #(
  parameter int TICK_DIV = 128
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int C_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [C_W-1:0] C_LAST = C_W'(TICK_DIV - 1);

  logic [C_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= (r_cnt == C_LAST) ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_tick = i_en && (r_cnt == C_LAST);

endmodule
`default_nettype wire

// File: rtl/adc_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : adc_sample_scheduler
// Description : Paces ADC sample sweeps, grants each enabled channel one SPI
//               conversion per sweep in ascending order, and opens the
//               transmitter burst window at the start of an acquisition.
// Options     : SCHED_TIMEOUT_EN - when defined, a watchdog aborts a
//               conversion after TIMEOUT cycles without adc_fin.
// Ports       : i_sys_clk      - system clock
//               i_reset        - synchronous active-high reset
//               i_start        - begin acquisition (ignored while busy)
//               i_stop         - end acquisition after in-flight conversion
//               i_ch_mask      - channel enables, latched at start
//               i_fifo_full    - per-channel FIFO full (skip conversion)
//               i_adc_fin      - per-channel conversion-done pulse
//               o_adc_en       - per-channel SPI enable (one-hot or zero)
//               o_cur_ch       - channel index being converted
//               o_tx_gate      - transmitter enable window
//               o_busy         - acquisition in progress
//               o_done         - one-cycle pulse at acquisition end
//               o_sample_idx   - sweeps completed
//               o_miss_cnt     - ticks lost while a sweep was running
//               o_drop_cnt     - conversions skipped or aborted
//               o_timeout_err  - sticky watchdog error
// Revision    : 1.0 - initial release
// ============================================================================
module adc_sample_scheduler
  import adc_sample_scheduler_pkg::*;
#(
  parameter int N_ADC       = 5,
  parameter int TICK_DIV    = 128,
  parameter int SAMPLES     = 4096,
  parameter int BURST_TICKS = 32,
  parameter int TIMEOUT     = 255
) (
  input  logic               i_sys_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
  input  logic [N_ADC-1:0]   i_ch_mask,
  input  logic [N_ADC-1:0]   i_fifo_full,
  input  logic [N_ADC-1:0]   i_adc_fin,
  output logic [N_ADC-1:0]   o_adc_en,
  output logic [2:0]         o_cur_ch,
  output logic               o_tx_gate,
  output logic               o_busy,
  output logic               o_done,
  output logic [C_CNT_W-1:0] o_sample_idx,
  output logic [C_CNT_W-1:0] o_miss_cnt,
  output logic [C_CNT_W-1:0] o_drop_cnt,
  output logic               o_timeout_err
);

  localparam logic [C_CNT_W-1:0] C_LAST_SAMPLE = C_CNT_W'(SAMPLES - 1);
  localparam logic [C_CNT_W-1:0] C_LAST_BURST  = C_CNT_W'(BURST_TICKS - 1);

  sched_state_t       r_state, w_state_nxt;
  logic [N_ADC-1:0]   r_mask, r_adc_en, w_ch_oh;
  logic [2:0]         r_ch, r_cur_ch, w_first, w_next;
  logic               w_first_vld, w_next_vld;
  logic               r_tx_gate, r_busy, r_done, r_stop_pend;
  logic [C_CNT_W-1:0] r_sample_idx, r_miss_cnt, r_drop_cnt, r_burst_cnt;
  logic               w_tick, w_start_go, w_stop_any, w_fin, w_full;
  logic               w_timeout, w_last_sweep, w_conv_end, w_sweep_end;

  adc_sample_scheduler_tick_gen #(
    .TICK_DIV (TICK_DIV)
  ) u_tick_gen (
    .i_clk  (i_sys_clk),
    .i_rst  (i_reset),
    .i_clr  (w_start_go),
    .i_en   (r_busy),
    .o_tick (w_tick)
  );

  // Lowest enabled channel, and the lowest enabled channel above r_ch.
  // Scanning downward lets the last hit win, i.e. the lowest index.
  always_comb begin
    w_first_vld = 1'b0;
    w_first     = '0;
    w_next_vld  = 1'b0;
    w_next      = '0;
    w_ch_oh     = '0;
    for (int i = N_ADC - 1; i >= 0; i--) begin
      if (r_mask[i]) begin
        w_first_vld = 1'b1;
        w_first     = 3'(i);
        if (3'(i) > r_ch) begin
          w_next_vld = 1'b1;
          w_next     = 3'(i);
        end
      end
      w_ch_oh[i] = (r_ch == 3'(i));
    end
  end

  assign w_start_go   = (r_state == S_IDLE) && i_start;
  assign w_stop_any   = r_stop_pend || i_stop;
  // r_adc_en is one-hot on r_ch during CONVERT, so this ignores other channels.
  assign w_fin        = |(i_adc_fin & r_adc_en);
  assign w_full       = |(i_fifo_full & w_ch_oh);
  assign w_last_sweep = (r_sample_idx == C_LAST_SAMPLE);

  // State register
  always_ff @(posedge i_sys_clk) begin
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_state_nxt;
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      S_IDLE:      if (i_start) w_state_nxt = S_WAIT_TICK;
      S_WAIT_TICK: begin
        if (w_stop_any)  w_state_nxt = S_FINISH;
        else if (w_tick) w_state_nxt = w_first_vld ? S_ARM : S_NEXT;
      end
      S_ARM:       w_state_nxt = w_full ? S_NEXT : S_CONVERT;
      S_CONVERT:   if (w_fin || w_timeout) w_state_nxt = S_NEXT;
      S_NEXT: begin
        if (w_stop_any)        w_state_nxt = S_FINISH;
        else if (w_next_vld)   w_state_nxt = S_ARM;
        else if (w_last_sweep) w_state_nxt = S_FINISH;
        else                   w_state_nxt = S_WAIT_TICK;
      end
      S_FINISH:    w_state_nxt = S_IDLE;
      default:     w_state_nxt = S_IDLE;
    endcase
  end

  // Output decode: strobes that steer the registered datapath
  always_comb begin
    w_conv_end  = (r_state == S_CONVERT) && (w_fin || w_timeout);
    // A sweep is complete only when no higher channel remains; a stop that
    // lands mid-sweep finishes without counting the partial sweep.
    w_sweep_end = (r_state == S_NEXT) && !w_next_vld;
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_reset) begin
      r_mask       <= '0;
      r_ch         <= '0;
      r_cur_ch     <= '0;
      r_adc_en     <= '0;
      r_tx_gate    <= 1'b0;
      r_busy       <= 1'b0;
      r_done       <= 1'b0;
      r_stop_pend  <= 1'b0;
      r_sample_idx <= '0;
      r_miss_cnt   <= '0;
      r_drop_cnt   <= '0;
      r_burst_cnt  <= '0;
    end else begin
      r_done <= 1'b0;
      if (w_start_go) begin
        r_mask       <= i_ch_mask;
        r_sample_idx <= '0;
        r_miss_cnt   <= '0;
        r_drop_cnt   <= '0;
        r_burst_cnt  <= '0;
        r_busy       <= 1'b1;
        r_tx_gate    <= 1'b1;
        r_stop_pend  <= i_stop;
      end else if (r_state != S_IDLE) begin
        if (i_stop) r_stop_pend <= 1'b1;
        // Every tick counts toward the burst window, serviced or missed.
        if (w_tick) begin
          r_burst_cnt <= sat_inc(r_burst_cnt);
          if (r_burst_cnt == C_LAST_BURST) r_tx_gate <= 1'b0;
          if (r_state != S_WAIT_TICK) r_miss_cnt <= sat_inc(r_miss_cnt);
        end
        if ((r_state == S_WAIT_TICK) && !w_stop_any && w_tick) r_ch <= w_first;
        if (r_state == S_ARM) begin
          if (w_full) begin
            r_drop_cnt <= sat_inc(r_drop_cnt);
          end else begin
            r_adc_en <= w_ch_oh;
            r_cur_ch <= r_ch;
          end
        end
        if (w_conv_end) begin
          r_adc_en <= '0;
          if (w_timeout) r_drop_cnt <= sat_inc(r_drop_cnt);
        end
        if ((r_state == S_NEXT) && !w_stop_any && w_next_vld) r_ch <= w_next;
        if (w_sweep_end) r_sample_idx <= sat_inc(r_sample_idx);
        if (r_state == S_FINISH) begin
          r_done      <= 1'b1;
          r_busy      <= 1'b0;
          r_tx_gate   <= 1'b0;
          r_stop_pend <= 1'b0;
        end
      end
    end
  end

`ifdef SCHED_TIMEOUT_EN
  localparam logic [C_CNT_W-1:0] C_WDOG_LAST = C_CNT_W'(TIMEOUT - 1);

  logic [C_CNT_W-1:0] r_wdog;
  logic               r_timeout_err;

  // Counts cycles spent in CONVERT; restarts on every new conversion.
  always_ff @(posedge i_sys_clk) begin
    if (i_reset || (r_state != S_CONVERT)) r_wdog <= '0;
    else                                   r_wdog <= r_wdog + 1'b1;
  end

  assign w_timeout = (r_state == S_CONVERT) && !w_fin && (r_wdog == C_WDOG_LAST);

  always_ff @(posedge i_sys_clk) begin
    if (i_reset || w_start_go) r_timeout_err <= 1'b0;
    else if (w_timeout)        r_timeout_err <= 1'b1;
  end

  assign o_timeout_err = r_timeout_err;
`else
  assign w_timeout     = 1'b0;
  assign o_timeout_err = 1'b0;
`endif

  assign o_adc_en     = r_adc_en;
  assign o_cur_ch     = r_cur_ch;
  assign o_tx_gate    = r_tx_gate;
  assign o_busy       = r_busy;
  assign o_done       = r_done;
  assign o_sample_idx = r_sample_idx;
  assign o_miss_cnt   = r_miss_cnt;
  assign o_drop_cnt   = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_adc_sample_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_adc_sample_scheduler
// Description : Directed self-checking bench for adc_sample_scheduler.
//               dut_a: TICK_DIV=128, SAMPLES=3, BURST_TICKS=2
//               dut_b: TICK_DIV=32,  SAMPLES=3 (sweep slower than tick)
//               SPI masters are modelled as holding fin off until adc_en
//               has been high for LAT cycles.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_adc_sample_scheduler;

  localparam int LAT = 40;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic withhold = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic        start_a = 0, stop_a = 0;
  logic [4:0]  mask_a = '0, full_a = '0, fin_a = '0;
  logic [4:0]  en_a;
  logic [2:0]  cur_a;
  logic        gate_a, busy_a, done_a, terr_a;
  logic [15:0] idx_a, miss_a, drop_a;

  logic        start_b = 0, stop_b = 0;
  logic [4:0]  mask_b = '0, full_b = '0, fin_b = '0;
  logic [4:0]  en_b;
  logic [2:0]  cur_b;
  logic        gate_b, busy_b, done_b, terr_b;
  logic [15:0] idx_b, miss_b, drop_b;

  int cnt_a [5];
  int cnt_b [5];

  adc_sample_scheduler #(
    .N_ADC(5), .TICK_DIV(128), .SAMPLES(3), .BURST_TICKS(2), .TIMEOUT(255)
  ) dut_a (
    .i_sys_clk(clk), .i_reset(rst), .i_start(start_a), .i_stop(stop_a),
    .i_ch_mask(mask_a), .i_fifo_full(full_a), .i_adc_fin(fin_a),
    .o_adc_en(en_a), .o_cur_ch(cur_a), .o_tx_gate(gate_a), .o_busy(busy_a),
    .o_done(done_a), .o_sample_idx(idx_a), .o_miss_cnt(miss_a),
    .o_drop_cnt(drop_a), .o_timeout_err(terr_a)
  );

  adc_sample_scheduler #(
    .N_ADC(5), .TICK_DIV(32), .SAMPLES(3), .BURST_TICKS(32), .TIMEOUT(255)
  ) dut_b (
    .i_sys_clk(clk), .i_reset(rst), .i_start(start_b), .i_stop(stop_b),
    .i_ch_mask(mask_b), .i_fifo_full(full_b), .i_adc_fin(fin_b),
    .o_adc_en(en_b), .o_cur_ch(cur_b), .o_tx_gate(gate_b), .o_busy(busy_b),
    .o_done(done_b), .o_sample_idx(idx_b), .o_miss_cnt(miss_b),
    .o_drop_cnt(drop_b), .o_timeout_err(terr_b)
  );

  initial forever #5 clk = ~clk;

  // SPI master model: fin pulses once, in the LAT-th cycle of adc_en high.
  initial begin
    for (int i = 0; i < 5; i++) begin
      cnt_a[i] = 0;
      cnt_b[i] = 0;
    end
    forever begin
      @(negedge clk);
      for (int i = 0; i < 5; i++) begin
        cnt_a[i] = en_a[i] ? cnt_a[i] + 1 : 0;
        cnt_b[i] = en_b[i] ? cnt_b[i] + 1 : 0;
        fin_a[i] = !withhold && (cnt_a[i] == LAT);
        fin_b[i] = (cnt_b[i] == LAT);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) step();
    checks++;
    if ({en_a, cur_a, gate_a, busy_a, done_a, idx_a, miss_a, drop_a, terr_a} !== 60'd0) begin
      errors++;
      $display("FAIL reset_a: got %h expected 0", {en_a, cur_a, gate_a, busy_a, done_a, idx_a, miss_a, drop_a, terr_a});
    end
    checks++;
    if ({en_b, cur_b, gate_b, busy_b, done_b, idx_b, miss_b, drop_b, terr_b} !== 60'd0) begin
      errors++;
      $display("FAIL reset_b: got %h expected 0", {en_b, cur_b, gate_b, busy_b, done_b, idx_b, miss_b, drop_b, terr_b});
    end
    rst = 1'b0;
    step();
  endtask

  task automatic test_reset_mid_convert();
    mask_a = 5'b00001;
    withhold = 1'b1;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int c = 1; c < 179; c++) step();
    checks++;
    if (en_a !== 5'b00001) begin
      errors++; $display("FAIL midconv_en_held: got %b expected 00001", en_a);
    end
    rst = 1'b1; step();
    checks++;
    if ({en_a, cur_a, gate_a, busy_a, done_a, idx_a, miss_a, drop_a, terr_a} !== 60'd0) begin
      errors++;
      $display("FAIL midconv_reset: got %h expected 0", {en_a, cur_a, gate_a, busy_a, done_a, idx_a, miss_a, drop_a, terr_a});
    end
    rst = 1'b0; withhold = 1'b0;
    step();
  endtask

  task automatic test_basic();
    logic [4:0] seq[$];
    logic [4:0] prev;
    int first_en, done_cyc, done_len, cur_bad, seq_bad, gate1, gate2;
    logic busy_at_done;
    prev = '0; first_en = -1; done_cyc = -1; done_len = 0; cur_bad = 0;
    seq_bad = 0; gate1 = -1; gate2 = -1; busy_at_done = 1'b1;
    mask_a = 5'b00101;
    start_a = 1'b1; step(); start_a = 1'b0;
    checks++;
    if ({busy_a, gate_a, en_a, idx_a} !== {1'b1, 1'b1, 5'd0, 16'd0}) begin
      errors++; $display("FAIL basic_start: got busy=%b gate=%b en=%b idx=%0d expected 1 1 00000 0", busy_a, gate_a, en_a, idx_a);
    end
    for (int c = 1; c <= 700; c++) begin
      step();
      if (en_a != prev && en_a != 5'd0) begin
        seq.push_back(en_a);
        if (first_en < 0) first_en = c;
        if (cur_a !== ((en_a == 5'b00001) ? 3'd0 : 3'd2)) cur_bad++;
      end
      prev = en_a;
      if (done_a) begin
        done_len++;
        if (done_cyc < 0) begin done_cyc = c; busy_at_done = busy_a; end
      end
      if (idx_a == 16'd1 && gate1 < 0) gate1 = int'(gate_a);
      if (idx_a == 16'd2 && gate2 < 0) gate2 = int'(gate_a);
      if (done_cyc >= 0 && c > done_cyc + 3) break;
    end
    for (int k = 0; k < seq.size(); k++)
      if (seq[k] !== ((k % 2 == 0) ? 5'b00001 : 5'b00100)) seq_bad++;
    checks++;
    if (first_en !== 129) begin errors++; $display("FAIL basic_first_en: got %0d expected 129", first_en); end
    checks++;
    if (seq.size() !== 6 || seq_bad !== 0) begin errors++; $display("FAIL basic_en_seq: got %0d entries %0d wrong expected 6 entries 0 wrong", seq.size(), seq_bad); end
    checks++;
    if (cur_bad !== 0) begin errors++; $display("FAIL basic_cur_ch: got %0d wrong expected 0", cur_bad); end
    checks++;
    if (done_cyc !== 469) begin errors++; $display("FAIL basic_done_cycle: got %0d expected 469", done_cyc); end
    checks++;
    if (done_len !== 1 || busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_done_pulse: got len=%0d busy=%b expected 1 0", done_len, busy_at_done); end
    checks++;
    if (idx_a !== 16'd3) begin errors++; $display("FAIL basic_sample_idx: got %0d expected 3", idx_a); end
    checks++;
    if (miss_a !== 16'd0 || drop_a !== 16'd0) begin errors++; $display("FAIL basic_miss_drop: got %0d %0d expected 0 0", miss_a, drop_a); end
    checks++;
    if (gate1 !== 1 || gate2 !== 0) begin errors++; $display("FAIL basic_tx_gate_burst: got %0d %0d expected 1 0", gate1, gate2); end
    checks++;
    if (gate_a !== 1'b0 || busy_a !== 1'b0) begin errors++; $display("FAIL basic_idle_after: got gate=%b busy=%b expected 0 0", gate_a, busy_a); end
  endtask

  task automatic test_fifo_full();
    logic [4:0] seen;
    int done_cyc;
    seen = '0; done_cyc = -1;
    mask_a = 5'b00101; full_a = 5'b00100;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int c = 1; c <= 700; c++) begin
      step();
      seen = seen | en_a;
      if (done_a && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c > done_cyc + 3) break;
    end
    full_a = '0;
    checks++;
    if (seen !== 5'b00001) begin errors++; $display("FAIL fifo_en_seen: got %b expected 00001", seen); end
    checks++;
    if (drop_a !== 16'd3 || idx_a !== 16'd3) begin errors++; $display("FAIL fifo_drop_idx: got drop=%0d idx=%0d expected 3 3", drop_a, idx_a); end
    checks++;
    if (done_cyc !== 429) begin errors++; $display("FAIL fifo_done_cycle: got %0d expected 429", done_cyc); end
  endtask

  task automatic test_stop();
    logic [4:0] prev;
    int fall, done_cyc, hi2;
    prev = '0; fall = -1; done_cyc = -1; hi2 = 0;
    mask_a = 5'b00101;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int c = 1; c <= 500; c++) begin
      step();
      if (c == 180) stop_a = 1'b1;
      if (c == 181) stop_a = 1'b0;
      if (en_a == 5'b00100) hi2++;
      if (prev == 5'b00100 && en_a == 5'd0 && fall < 0) fall = c;
      prev = en_a;
      if (done_a && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c > done_cyc + 3) break;
    end
    checks++;
    if (fall !== 211 || hi2 !== 40) begin errors++; $display("FAIL stop_frame_kept: got fall=%0d high=%0d expected 211 40", fall, hi2); end
    checks++;
    if (done_cyc !== 213) begin errors++; $display("FAIL stop_done_cycle: got %0d expected 213", done_cyc); end
    checks++;
    if (idx_a !== 16'd1) begin errors++; $display("FAIL stop_sample_idx: got %0d expected 1", idx_a); end
  endtask

  task automatic test_miss();
    int done_cyc, pulses;
    logic [4:0] prev;
    done_cyc = -1; pulses = 0; prev = '0;
    mask_b = 5'b00001;
    start_b = 1'b1; step(); start_b = 1'b0;
    for (int c = 1; c <= 400; c++) begin
      step();
      if (prev == 5'd0 && en_b != 5'd0) pulses++;
      prev = en_b;
      if (done_b && done_cyc < 0) done_cyc = c;
      if (done_cyc >= 0 && c > done_cyc + 3) break;
    end
    checks++;
    if (miss_b !== 16'd3) begin errors++; $display("FAIL miss_count: got %0d expected 3", miss_b); end
    checks++;
    if (idx_b !== 16'd3 || pulses !== 3) begin errors++; $display("FAIL miss_sweeps: got idx=%0d pulses=%0d expected 3 3", idx_b, pulses); end
    checks++;
    if (done_cyc !== 203) begin errors++; $display("FAIL miss_done_cycle: got %0d expected 203", done_cyc); end
  endtask

  task automatic test_timeout();
`ifdef SCHED_TIMEOUT_EN
    int rise, fall;
    logic terr_f;
    logic [15:0] drop_f;
    rise = -1; fall = -1; terr_f = 1'b0; drop_f = '0;
    mask_a = 5'b00001; withhold = 1'b1;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int c = 1; c <= 600; c++) begin
      step();
      if (en_a != 5'd0 && rise < 0) rise = c;
      if (rise >= 0 && en_a == 5'd0 && fall < 0) begin
        fall = c; terr_f = terr_a; drop_f = drop_a;
      end
      if (fall >= 0) break;
    end
    checks++;
    if (rise !== 129 || fall !== 384) begin errors++; $display("FAIL timeout_window: got rise=%0d fall=%0d expected 129 384", rise, fall); end
    checks++;
    if (terr_f !== 1'b1) begin errors++; $display("FAIL timeout_err: got %b expected 1", terr_f); end
    checks++;
    if (drop_f !== 16'd1) begin errors++; $display("FAIL timeout_drop: got %0d expected 1", drop_f); end
`else
    mask_a = 5'b00001; withhold = 1'b1;
    start_a = 1'b1; step(); start_a = 1'b0;
    for (int c = 1; c <= 429; c++) step();
    checks++;
    if (en_a !== 5'b00001) begin errors++; $display("FAIL nowdog_en_held: got %b expected 00001", en_a); end
    checks++;
    if (terr_a !== 1'b0) begin errors++; $display("FAIL nowdog_err: got %b expected 0", terr_a); end
    checks++;
    if (drop_a !== 16'd0) begin errors++; $display("FAIL nowdog_drop: got %0d expected 0", drop_a); end
`endif
    rst = 1'b1; step(); rst = 1'b0; withhold = 1'b0;
    step();
  endtask

  initial begin
    test_reset();
    test_reset_mid_convert();
    test_basic();
    test_fifo_full();
    test_stop();
    test_miss();
    test_timeout();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adc_sample_scheduler.md
# adc_sample_scheduler

Sequences the ADC SPI masters for one acquisition: it paces sample sweeps from SYS_CLK, grants each enabled ADC channel its conversion in turn, and gates the ultrasonic transmitter burst at the start of the run. It sits between the top-level control (switches/keys) and the SPI_MASTER_ADC instances and their per-channel FIFOs. It replaces the free-running auto-sample counter with a bounded, backpressure-aware acquisition.

## Interface
- N_ADC, 5, number of ADC channels (1..8)
- TICK_DIV, 128, SYS_CLK cycles per sample sweep (128 at 40 MHz gives 312.5 kHz)
- SAMPLES, 4096, sweeps per acquisition (1..65535)
- BURST_TICKS, 32, sweep ticks for which tx_gate is high after start
- TIMEOUT, 255, max SYS_CLK cycles a channel may hold adc_en without adc_fin (feature-gated)

Ports:
- SYS_CLK  in  1  system clock (40 MHz)
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse; begins an acquisition when idle
- stop  in  1  one-cycle pulse; ends the acquisition after any in-flight conversion
- ch_mask  in  N_ADC  channel enables, latched at start
- fifo_full  in  N_ADC  per-channel FIFO full
- adc_fin  in  N_ADC  per-channel conversion-done pulse from the SPI master
- adc_en  out  N_ADC  per-channel SPI enable, one-hot or zero
- cur_ch  out  3  index of the channel being converted
- tx_gate  out  1  transmitter enable window
- busy  out  1  acquisition in progress
- done  out  1  one-cycle pulse at the end of an acquisition
- sample_idx  out  16  sweeps completed in this acquisition
- miss_cnt  out  16  ticks lost because a sweep was still running
- drop_cnt  out  16  conversions skipped because the FIFO was full
- timeout_err  out  1  sticky; a channel never returned adc_fin

## Operation
- States: IDLE, WAIT_TICK, ARM, CONVERT, NEXT, FINISH.
- IDLE: start moves to WAIT_TICK. On that move the block:
  - latches ch_mask;
  - clears tick_cnt, sample_idx, miss_cnt, drop_cnt and timeout_err;
  - sets busy and tx_gate.
- tick_cnt runs 0..TICK_DIV-1 and wraps while busy. A tick occurs when tick_cnt == TICK_DIV-1.
- WAIT_TICK:
  - on tick, go to ARM with ch = the lowest enabled channel;
  - if the mask is empty, go to NEXT.
- ARM:
  - if fifo_full[ch], increment drop_cnt (saturating) and go to NEXT;
  - otherwise set adc_en[ch] and go to CONVERT.
- CONVERT: hold adc_en[ch] until adc_fin[ch] is seen, then clear adc_en and go to NEXT. adc_fin on other channels is ignored.
- NEXT:
  - if a higher enabled channel remains, set ch to it and go to ARM;
  - otherwise increment sample_idx and go to WAIT_TICK, or go to FINISH if sample_idx+1 == SAMPLES or stop is pending.
- FINISH: pulse done, clear busy and tx_gate, go to IDLE.
- A tick that arrives in any state other than WAIT_TICK increments miss_cnt (saturating) and is discarded.
- tx_gate clears after BURST_TICKS ticks, counting both serviced and missed ticks, or at FINISH, whichever comes first.
- stop is latched as pending:
  - in WAIT_TICK it goes directly to FINISH;
  - in other states it takes effect at the next NEXT. It never truncates an SPI frame.
- start while busy is ignored. start and stop in the same cycle from IDLE: start wins, and stop becomes pending.

## Timing
- Reset value of all outputs is 0. The state returns to IDLE on the next edge, including when reset arrives mid-conversion, where adc_en drops immediately.
- adc_en rises 1 cycle after ARM and falls 1 cycle after the adc_fin edge.
- The first adc_en occurs TICK_DIV+1 cycles after start.
- Sweep overhead is 3 cycles per channel in addition to SPI time. Any excess over TICK_DIV appears as miss_cnt increments.
- done is high for exactly 1 cycle. busy falls in the same cycle that done rises.
- cur_ch is registered and valid whenever adc_en is nonzero.

## Configuration
- SCHED_TIMEOUT_EN defined:
  - a watchdog counts CONVERT cycles;
  - at TIMEOUT it forces adc_en low, sets timeout_err, counts a drop, and goes to NEXT.
- SCHED_TIMEOUT_EN undefined:
  - CONVERT waits indefinitely;
  - timeout_err is tied to 0.

## Structure
- A shared package holds:
  - the state enum;
  - the counter width constant (16);
  - the saturating-increment function used by sample_idx, miss_cnt and drop_cnt.
- One natural sub-module is sched_tick_gen: the TICK_DIV counter plus its tick pulse, with a clear input driven on start.
- The channel-select priority logic ("next enabled channel above ch") stays inline.

## Test plan
- N_ADC=5, mask=5'b00101, SPI master model returning fin 40 cycles after en, SAMPLES=3 -> adc_en sequence 00001, 00100 repeated 3 times; sample_idx=3; done pulse; miss_cnt=0.
- fifo_full[2] held high, mask=5'b00101 -> channel 2 never enabled; drop_cnt equals sweeps completed.
- TICK_DIV=32, fin latency 40 -> miss_cnt increments once per sweep; sample_idx still reaches SAMPLES.
- stop issued mid-CONVERT -> adc_en stays high until fin; done 2 cycles later; sample_idx = sweeps completed.
- reset asserted mid-CONVERT -> next edge: all outputs 0 and state IDLE; start then works normally.
- SCHED_TIMEOUT_EN defined, fin withheld, TIMEOUT=255 -> adc_en drops after 255 cycles; timeout_err=1; drop_cnt=1.
